// File: rtl/uart_cmd_parse.sv
// -----------------------------------------------------------------------------
// uart_cmd_parse
//
// Assembles 8-byte command frames from the UART receive byte stream into
// single SDRAM access requests, offered downstream on a valid/ready handshake.
//
// Frame: HEADER, OP, A2, A1, A0, DH, DL, CHK   with CHK = XOR(OP..DL)
//
// Ports:
//   sysclk     in   system clock, rising edge
//   nrst       in   synchronous reset, active-low
//   rx_done    in   1-cycle strobe from UART receiver (byte follows next cycle)
//   rx_data    in   received byte, valid the cycle after rx_done
//   cmd_ready  in   downstream accepts command when high with cmd_valid
//   cmd_valid  out  command available, held until accepted
//   cmd_wr     out  1 = write, 0 = read
//   cmd_addr   out  SDRAM word address {A2,A1,A0}
//   cmd_wdata  out  write data {DH,DL}
//   frame_err  out  1-cycle pulse on bad checksum, bad opcode or timeout
//   overrun    out  1-cycle pulse when a byte is dropped while a command pends
//   busy       out  high whenever the parser is not hunting for a header
// -----------------------------------------------------------------------------
module uart_cmd_parse #(
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter logic [23:0] TIMEOUT = 24'd104180,
  parameter logic [7:0]  OP_WR   = 8'h01,
  parameter logic [7:0]  OP_RD   = 8'h02
) (
  input  logic        sysclk,
  input  logic        nrst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic        cmd_wr,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    ISSUE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        byte_stb_q, byte_stb_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [23:0] cnt_q, cnt_d;

  // Payload bytes OP..DL; the CHK byte only feeds the running XOR.
  logic [7:0]  frame_q [6];
  logic [7:0]  frame_d [6];

  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_wdata_q, cmd_wdata_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;

  logic        op_ok;

  // The receiver presents the byte one cycle after its strobe, so the
  // registered strobe lines up with rx_data.
  assign byte_stb_d = rx_done;

  assign op_ok = (frame_q[0] == OP_WR) || (frame_q[0] == OP_RD);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      HUNT: begin
        // Non-header bytes are dropped silently.
        if (byte_stb_q && (rx_data == HEADER)) begin
          state_d = COLLECT;
          idx_d   = 3'd0;
          chk_d   = 8'h00;
          cnt_d   = 24'd0;
        end
      end

      COLLECT: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (byte_stb_q) begin
          if (idx_q < 3'd6) begin
            frame_d[idx_q] = rx_data;
          end
          chk_d = chk_q ^ rx_data;
          idx_d = idx_q + 3'd1;
          cnt_d = 24'd0;
          if (idx_q == 3'd6) begin
            state_d = CHECK;
          end
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      CHECK: begin
        // XOR over OP..CHK is zero for an intact frame.
        if ((chk_q == 8'h00) && op_ok) begin
          cmd_valid_d = 1'b1;
          cmd_wr_d    = (frame_q[0] == OP_WR);
          cmd_addr_d  = {frame_q[1], frame_q[2], frame_q[3]};
          cmd_wdata_d = {frame_q[4], frame_q[5]};
          state_d     = ISSUE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
        end
        if (byte_stb_q) begin
          overrun_d = 1'b1;
        end
      end

      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = HUNT;
        end
        // Even a header byte is dropped here; it never opens a new frame.
        if (byte_stb_q) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // Registered from the next state so busy tracks state_q exactly.
    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge sysclk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!nrst) begin
      state_q     <= HUNT;
      byte_stb_q  <= 1'b0;
      idx_q       <= 3'd0;
      chk_q       <= 8'h00;
      cnt_q       <= 24'd0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= 24'd0;
      cmd_wdata_q <= 16'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_stb_q  <= byte_stb_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the payload store is deliberately not reset; CHECK is only reached
  // after all six entries of the current frame have been written.
  always_ff @(posedge sysclk) begin
    frame_q <= frame_d;
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parse.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parse
//
// Self-checking bench for uart_cmd_parse. A negedge monitor logs frame_err,
// overrun, cmd_valid rises and accepted commands with their cycle numbers;
// each test task compares that log against expectations derived from the
// frame bytes (XOR checksum, opcode rule, fixed N+3 latency, timeout window).
// -----------------------------------------------------------------------------
module tb_uart_cmd_parse;

  localparam int TO = 40;

  logic        sysclk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  uart_cmd_parse #(
    .HEADER (8'hAA),
    .TIMEOUT(24'(TO)),
    .OP_WR  (8'h01),
    .OP_RD  (8'h02)
  ) dut (
    .sysclk   (sysclk),
    .nrst     (nrst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 sysclk = ~sysclk;

  typedef logic [7:0] frame_t [8];

  typedef struct {
    int          cyc;
    logic        wr;
    logic [23:0] addr;
    logic [15:0] wdata;
  } acc_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   err_q[$];
  int   ovr_q[$];
  int   rise_q[$];
  acc_t acc_q[$];
  int   vcyc = 0;
  logic valid_prev = 1'b0;
  acc_t mon_a;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (nrst) begin
      if (frame_err) err_q.push_back(cyc);
      if (overrun) ovr_q.push_back(cyc);
      if (cmd_valid) vcyc++;
      if (cmd_valid && !valid_prev) rise_q.push_back(cyc);
      if (cmd_valid && cmd_ready) begin
        mon_a.cyc   = cyc;
        mon_a.wr    = cmd_wr;
        mon_a.addr  = cmd_addr;
        mon_a.wdata = cmd_wdata;
        acc_q.push_back(mon_a);
      end
    end
    valid_prev = cmd_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: outcome of a frame purely from its bytes.
  // ---------------------------------------------------------------------------
  function automatic void model(input frame_t f, output bit good, output logic wr,
                                output logic [23:0] addr, output logic [15:0] wdata);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < 8; i++) x = x ^ f[i];
    good  = (f[0] == 8'hAA) && (x == 8'h00) && ((f[1] == 8'h01) || (f[1] == 8'h02));
    wr    = (f[1] == 8'h01);
    addr  = {f[2], f[3], f[4]};
    wdata = {f[5], f[6]};
  endfunction

  function automatic void make_frame(input logic [7:0] op, input logic [23:0] addr,
                                     input logic [15:0] wdata, input bit corrupt,
                                     output frame_t f);
    f[0] = 8'hAA;
    f[1] = op;
    f[2] = addr[23:16];
    f[3] = addr[15:8];
    f[4] = addr[7:0];
    f[5] = wdata[15:8];
    f[6] = wdata[7:0];
    f[7] = op ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ wdata[15:8] ^ wdata[7:0];
    if (corrupt) f[7] = f[7] ^ 8'($urandom_range(255, 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) idle(1);
  endtask

  // n returns the cycle in which rx_done was high.
  task automatic send_byte(input logic [7:0] b, output int n);
    rx_done = 1'b1;
    rx_data = 8'($urandom);
    n = cyc;
    idle(1);
    rx_done = 1'b0;
    rx_data = b;
    idle(1);
    rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input frame_t f, input int max_gap, output int n_last);
    int n;
    for (int i = 0; i < 8; i++) begin
      send_byte(f[i], n);
      if (i < 7 && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
    end
    n_last = n;
  endtask

  task automatic clear_log();
    err_q.delete();
    ovr_q.delete();
    rise_q.delete();
    acc_q.delete();
    vcyc = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    nrst = 1'b0;
    idle(3);
    checks++;
    if ({cmd_valid, cmd_wr, frame_err, overrun, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {cmd_valid, cmd_wr, frame_err, overrun, busy});
    end
    checks++;
    if (cmd_addr !== 24'h0 || cmd_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_fields: got addr=%h wdata=%h expected 0/0", cmd_addr, cmd_wdata);
    end
    nrst = 1'b1;
    idle(2);
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b valid=%b expected 0/0", busy, cmd_valid);
    end
  endtask

  task automatic test_good_write();
    frame_t f;
    bit g; logic wr; logic [23:0] a; logic [15:0] d;
    int n, got;
    clear_log();
    cmd_ready = 1'b1;
    f = '{8'hAA, 8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'h17};
    model(f, g, wr, a, d);
    send_frame(f, 2, n);
    wait_until(n + 8);
    got = (rise_q.size() == 1) ? rise_q[0] : -1;
    checks++;
    if (got !== n + 3) begin
      errors++;
      $display("FAIL wr_latency: got valid rise at %0d expected %0d", got, n + 3);
    end
    checks++;
    if (vcyc !== 1) begin
      errors++;
      $display("FAIL wr_pulse_len: got %0d valid cycles expected 1", vcyc);
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0].wr !== wr || acc_q[0].addr !== a || acc_q[0].wdata !== d) begin
      errors++;
      $display("FAIL wr_fields: got %0d accepts (first wr=%b addr=%h wdata=%h) expected 1 (%b %h %h)",
               acc_q.size(), (acc_q.size() > 0) ? acc_q[0].wr : 1'bx,
               (acc_q.size() > 0) ? acc_q[0].addr : 24'hx,
               (acc_q.size() > 0) ? acc_q[0].wdata : 16'hx, wr, a, d);
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL wr_no_err: got %0d frame_err pulses expected 0", err_q.size());
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    frame_t f;
    bit g; logic wr; logic [23:0] a; logic [15:0] d;
    int n, m, unstable, got;
    clear_log();
    cmd_ready = 1'b0;
    f = '{8'hAA, 8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h12};
    model(f, g, wr, a, d);
    send_frame(f, 1, n);
    wait_until(n + 3);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_wr !== wr || cmd_addr !== a || cmd_wdata !== d) begin
      errors++;
      $display("FAIL bp_fields: got v=%b wr=%b addr=%h wdata=%h expected 1 %b %h %h",
               cmd_valid, cmd_wr, cmd_addr, cmd_wdata, wr, a, d);
    end
    unstable = 0;
    m = -1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        rx_done = 1'b1;
        m = cyc;
      end else if (i == 11) begin
        rx_done = 1'b0;
        rx_data = 8'h55;
      end else begin
        rx_data = 8'($urandom);
      end
      if (cmd_valid !== 1'b1 || cmd_wr !== wr || cmd_addr !== a || cmd_wdata !== d) unstable++;
      idle(1);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable);
    end
    got = (ovr_q.size() == 1) ? ovr_q[0] : -1;
    checks++;
    if (got !== m + 2) begin
      errors++;
      $display("FAIL bp_overrun: got %0d pulses (first at %0d) expected 1 at %0d", ovr_q.size(), got, m + 2);
    end
    checks++;
    if (busy !== 1'b1 || err_q.size() != 0) begin
      errors++;
      $display("FAIL bp_busy: got busy=%b errs=%0d expected 1/0", busy, err_q.size());
    end
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", cmd_valid, busy);
    end
    checks++;
    if (acc_q.size() != 1) begin
      errors++;
      $display("FAIL bp_accept: got %0d accepts expected 1", acc_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    frame_t f;
    int n, got;
    clear_log();
    cmd_ready = 1'b1;
    f = '{8'hAA, 8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'h18};
    send_frame(f, 2, n);
    wait_until(n + 6);
    got = (err_q.size() == 1) ? err_q[0] : -1;
    checks++;
    if (got !== n + 3) begin
      errors++;
      $display("FAIL chk_err: got %0d pulses (first at %0d) expected 1 at %0d", err_q.size(), got, n + 3);
    end
    checks++;
    if (vcyc !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL chk_noissue: got valid cycles=%0d busy=%b expected 0/0", vcyc, busy);
    end
    clear_log();
    f = '{8'hAA, 8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'h17};
    send_frame(f, 2, n);
    wait_until(n + 6);
    got = (acc_q.size() == 1) ? acc_q[0].cyc : -1;
    checks++;
    if (got !== n + 3 || err_q.size() != 0) begin
      errors++;
      $display("FAIL chk_recover: got accept at %0d errs=%0d expected %0d/0", got, err_q.size(), n + 3);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_bad_opcode();
    frame_t f;
    int n, got;
    clear_log();
    cmd_ready = 1'b1;
    f = '{8'hAA, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    send_frame(f, 2, n);
    wait_until(n + 6);
    got = (err_q.size() == 1) ? err_q[0] : -1;
    checks++;
    if (got !== n + 3 || vcyc !== 0) begin
      errors++;
      $display("FAIL op_err: got err at %0d valid cycles=%0d expected %0d/0", got, vcyc, n + 3);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n, m, got;
    bit g; logic wr; logic [23:0] a; logic [15:0] d;
    frame_t f;
    clear_log();
    send_byte(8'h00, m);
    send_byte(8'hFF, m);
    idle(5);
    checks++;
    if (err_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hunt_silent: got errs=%0d busy=%b expected 0/0", err_q.size(), busy);
    end
    send_byte(8'hAA, m);
    send_byte(8'h01, m);
    send_byte(8'h12, n);
    idle(TO - 1);
    checks++;
    if (busy !== 1'b1 || err_q.size() != 0) begin
      errors++;
      $display("FAIL to_early: got busy=%b errs=%0d at last live cycle expected 1/0", busy, err_q.size());
    end
    send_byte(8'h34, m);   // one cycle too late; dropped in HUNT
    wait_until(n + TO + 6);
    got = (err_q.size() == 1) ? err_q[0] : -1;
    checks++;
    if (got !== n + TO + 2) begin
      errors++;
      $display("FAIL to_err: got %0d pulses (first at %0d) expected 1 at %0d", err_q.size(), got, n + TO + 2);
    end
    checks++;
    if (busy !== 1'b0 || ovr_q.size() != 0) begin
      errors++;
      $display("FAIL to_idle: got busy=%b overruns=%0d expected 0/0", busy, ovr_q.size());
    end
    // Byte landing exactly on the expiry cycle keeps the frame alive.
    clear_log();
    cmd_ready = 1'b1;
    f = '{8'hAA, 8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'h17};
    model(f, g, wr, a, d);
    send_byte(f[0], m);
    send_byte(f[1], m);
    idle(TO - 2);
    for (int i = 2; i < 8; i++) send_byte(f[i], n);
    wait_until(n + 6);
    got = (acc_q.size() == 1) ? acc_q[0].cyc : -1;
    checks++;
    if (got !== n + 3 || err_q.size() != 0) begin
      errors++;
      $display("FAIL to_edge_alive: got accept at %0d errs=%0d expected %0d/0", got, err_q.size(), n + 3);
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0].addr !== a || acc_q[0].wdata !== d || acc_q[0].wr !== wr) begin
      errors++;
      $display("FAIL to_edge_fields: got %0d accepts expected 1 with addr=%h wdata=%h", acc_q.size(), a, d);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n, m, got;
    bit g; logic wr; logic [23:0] a; logic [15:0] d;
    frame_t f;
    clear_log();
    send_byte(8'hAA, m);
    send_byte(8'h01, m);
    send_byte(8'h12, m);
    send_byte(8'h34, m);
    nrst = 1'b0;
    idle(1);
    nrst = 1'b1;
    checks++;
    if ({cmd_valid, cmd_wr, frame_err, overrun, busy} !== 5'b0 || cmd_addr !== 24'h0 || cmd_wdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h wdata=%h expected all 0",
               {cmd_valid, cmd_wr, frame_err, overrun, busy}, cmd_addr, cmd_wdata);
    end
    idle(TO + 5);
    checks++;
    if (err_q.size() != 0 || ovr_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got errs=%0d overruns=%0d expected 0/0", err_q.size(), ovr_q.size());
    end
    cmd_ready = 1'b1;
    make_frame(8'h02, 24'($urandom), 16'($urandom), 1'b0, f);
    model(f, g, wr, a, d);
    send_frame(f, 2, n);
    wait_until(n + 6);
    got = (acc_q.size() == 1) ? acc_q[0].cyc : -1;
    checks++;
    if (got !== n + 3 || acc_q.size() != 1 || acc_q[0].addr !== a || acc_q[0].wr !== wr) begin
      errors++;
      $display("FAIL rst_mid_next: got accept at %0d (count %0d) expected %0d addr=%h", got, acc_q.size(), n + 3, a);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_random();
    frame_t f;
    bit g; logic wr; logic [23:0] a; logic [15:0] d;
    logic [7:0] op, j;
    int n, m, dly, got, sel;
    for (int it = 0; it < 25; it++) begin
      clear_log();
      cmd_ready = 1'b0;
      repeat ($urandom_range(2, 0)) begin
        j = 8'($urandom);
        if (j == 8'hAA) j = 8'h00;
        send_byte(j, m);
        idle(int'($urandom_range(3, 0)));
      end
      sel = int'($urandom_range(2, 0));
      op = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom);
      make_frame(op, 24'($urandom), 16'($urandom), ($urandom_range(4, 0) == 0), f);
      model(f, g, wr, a, d);
      dly = int'($urandom_range(5, 0));
      send_frame(f, 3, n);
      wait_until(n + 3 + dly);
      cmd_ready = 1'b1;
      idle(1);
      cmd_ready = 1'b0;
      idle(3);
      if (g) begin
        got = (acc_q.size() == 1) ? acc_q[0].cyc : -1;
        checks++;
        if (got !== n + 3 + dly || err_q.size() != 0) begin
          errors++;
          $display("FAIL rnd_good[%0d]: got accept at %0d errs=%0d expected %0d/0", it, got, err_q.size(), n + 3 + dly);
        end
        checks++;
        if (acc_q.size() != 1 || acc_q[0].wr !== wr || acc_q[0].addr !== a || acc_q[0].wdata !== d) begin
          errors++;
          $display("FAIL rnd_fields[%0d]: got %0d accepts expected 1 with wr=%b addr=%h wdata=%h", it, acc_q.size(), wr, a, d);
        end
      end else begin
        got = (err_q.size() == 1) ? err_q[0] : -1;
        checks++;
        if (got !== n + 3 || acc_q.size() != 0) begin
          errors++;
          $display("FAIL rnd_bad[%0d]: got err at %0d accepts=%0d expected %0d/0", it, got, acc_q.size(), n + 3);
        end
      end
      checks++;
      if (ovr_q.size() != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle[%0d]: got overruns=%0d busy=%b expected 0/0", it, ovr_q.size(), busy);
      end
    end
  endtask

  initial begin
    @(posedge sysclk);
    #1;
    test_reset();
    test_good_write();
    test_backpressure();
    test_bad_checksum();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
